a25_wishbone_resp_buf: RTL and testbench
========================================

Name: a25_wishbone_resp_buf

Overview:
Responder-side port buffer for the Amber valid/accepted request interface. It receives requests from a wishbone master port buffer (valid, write, wdata, be, addr), answers with accepted, and returns read data with a read-data-valid strobe. Accepted requests are queued in a 2-entry in-order FIFO and replayed onto a simple ready-stalled memory/peripheral backend. It sits between the wishbone arbiter output and on-chip RAM or a slave peripheral.

Parameters:
DATA_WIDTH, 128, request/response data width; BE width = DATA_WIDTH/8
ADDR_WIDTH, 32, address width

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  request valid from master
o_accepted  output  1  request taken this cycle (combinational)
i_write  input  1  1=write, 0=read
i_wdata  input  DATA_WIDTH  write data
i_be  input  DATA_WIDTH/8  byte enables
i_addr  input  ADDR_WIDTH  byte address
o_rdata  output  DATA_WIDTH  read data to master
o_rdata_valid  output  1  read data strobe, one cycle per read
o_mem_req  output  1  backend request valid
i_mem_ready  input  1  backend takes request this cycle
o_mem_write  output  1  backend write
o_mem_wdata  output  DATA_WIDTH  backend write data
o_mem_be  output  DATA_WIDTH/8  backend byte enables
o_mem_addr  output  ADDR_WIDTH  backend address
i_mem_rdata  input  DATA_WIDTH  backend read data
i_mem_rdata_valid  input  1  backend read data strobe

Behaviour:
- Reset (async, i_rst_n=0): FIFO count=0, write and read pointers=0, rd_pending_r=0; o_accepted=0, o_mem_req=0, o_rdata_valid=0, o_rdata=0 (registered path). FIFO storage is not reset. Reset mid-transfer drops all queued entries and any pending read; a later i_mem_rdata_valid is ignored.
- Accept rule: o_accepted = i_valid && count<2 && !(~i_write && rd_pending_r). The count test uses the current count only; there is no pop-through when full.
- Push on accept: store {write, wdata, addr, be}. For reads, be is stored as all-ones. Write pointer toggles.
- Accepting a read sets rd_pending_r. rd_pending_r clears on the cycle o_rdata_valid is asserted. At most one read is outstanding. Writes may still be accepted while a read is pending.
- Backend: o_mem_req = (count!=0). o_mem_* are driven from the FIFO head. Pop when o_mem_req && i_mem_ready, then the read pointer toggles. Order is strictly in-order; reads never bypass earlier writes.
- No same-cycle bypass: a request accepted in cycle N appears on o_mem_* no earlier than N+1.
- Simultaneous push and pop: count is unchanged. Push alone: count+1. Pop alone: count-1.
- o_mem_* fields are held stable while o_mem_req=1 and i_mem_ready=0.
- Read return: o_rdata_valid = i_mem_rdata_valid && rd_pending_r, and o_rdata = i_mem_rdata in the same cycle (combinational). An i_mem_rdata_valid with rd_pending_r=0 is ignored.
- Writes produce no response on this interface. The master acks writes itself.
- Throughput: 1 request/cycle sustained while count<=1 and the backend is ready every cycle.

Optional Feature:
A25_WB_RESP_RDATA_REG_EN
- Defined: o_rdata and o_rdata_valid are registered. Read return is 1 cycle after i_mem_rdata_valid. rd_pending_r clears on the registered strobe, so no new read is accepted until o_rdata_valid is seen.
- Undefined: combinational pass-through as described above, with zero added latency.

Test Plan:
- Single write: i_valid=1, i_write=1, addr=0x100, be=0x000F, wdata=0x...DEADBEEF, i_mem_ready=1 -> o_accepted=1 in cycle N; o_mem_req=1 in N+1 with the same addr/be/wdata; count returns to 0 in N+2; o_rdata_valid stays 0.
- Backpressure/full: i_mem_ready=0, three back-to-back writes to 0x0, 0x10, 0x20 -> first two accepted, third o_accepted=0 while count=2. Set i_mem_ready=1 -> backend sees 0x0, 0x10, then 0x20 (third accepted once count<2), in order.
- Read ordering: write 0x40 then read 0x40 with backend ready -> backend sees the write before the read; the read has o_mem_be=0xFFFF. Backend returns rdata=0x1234 -> o_rdata_valid=1 with o_rdata=0x1234 the same cycle (N+1 with A25_WB_RESP_RDATA_REG_EN).
- Second read while pending: read 0x80 accepted, read 0x90 presented before rdata returns -> o_accepted=0 until the cycle after o_rdata_valid. A write presented during the wait is accepted.
- Spurious data: i_mem_rdata_valid=1 with no read pending -> o_rdata_valid stays 0; FIFO state unchanged.
- Async reset mid-operation: 2 entries queued plus 1 read pending, assert i_rst_n=0 between clock edges -> o_mem_req and o_rdata_valid are 0 immediately and count=0. After release, the first accept goes to the backend with the correct fields.

Source files
------------

// File: rtl/a25_wishbone_resp_buf.sv
// Responder-side port buffer: a 2-entry in-order request FIFO in front of a ready-stalled backend.
// Optional macro A25_WB_RESP_RDATA_REG_EN registers the read-data return path.
module a25_wishbone_resp_buf #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_valid,
   output logic                      o_accepted,
   input  logic                      i_write,
   input  logic [DATA_WIDTH-1:0]     i_wdata,
   input  logic [DATA_WIDTH/8-1:0]   i_be,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   output logic [DATA_WIDTH-1:0]     o_rdata,
   output logic                      o_rdata_valid,
   output logic                      o_mem_req,
   input  logic                      i_mem_ready,
   output logic                      o_mem_write,
   output logic [DATA_WIDTH-1:0]     o_mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   o_mem_be,
   output logic [ADDR_WIDTH-1:0]     o_mem_addr,
   input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
   input  logic                      i_mem_rdata_valid
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic [1:0]            count_q, count_d;
   logic                  wrPtr_q, rdPtr_q;
   logic                  rdPending_q, rdPending_d;
   logic                  push, pop, rdataDone;

   logic                  writeMem_q [2];
   logic [DATA_WIDTH-1:0] wdataMem_q [2];
   logic [ADDR_WIDTH-1:0] addrMem_q  [2];
   logic [BE_WIDTH-1:0]   beMem_q    [2];

   // Only one read may be outstanding; the count check never looks at a same-cycle pop.
   assign o_accepted = i_valid && (count_q != 2'd2) && !(!i_write && rdPending_q);
   assign push       = o_accepted;
   assign o_mem_req  = (count_q != 2'd0);
   assign pop        = o_mem_req && i_mem_ready;

   assign o_mem_write = writeMem_q[rdPtr_q];
   assign o_mem_wdata = wdataMem_q[rdPtr_q];
   assign o_mem_addr  = addrMem_q[rdPtr_q];
   assign o_mem_be    = beMem_q[rdPtr_q];

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      rdPending_d = rdPending_q;
      if (push && !i_write)
         rdPending_d = 1'b1;
      else if (rdataDone)
         rdPending_d = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q     <= 2'd0;
         wrPtr_q     <= 1'b0;
         rdPtr_q     <= 1'b0;
         rdPending_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         rdPending_q <= rdPending_d;
         if (push)
            wrPtr_q <= ~wrPtr_q;
         if (pop)
            rdPtr_q <= ~rdPtr_q;
      end
   end

   // Storage needs no reset: entries are only observed once count marks them valid.
   always_ff @(posedge i_clk) begin
      if (push) begin
         writeMem_q[wrPtr_q] <= i_write;
         wdataMem_q[wrPtr_q] <= i_wdata;
         addrMem_q[wrPtr_q]  <= i_addr;
         beMem_q[wrPtr_q]    <= i_write ? i_be : {BE_WIDTH{1'b1}};
      end
   end

`ifdef A25_WB_RESP_RDATA_REG_EN
   logic                  rdataValid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  rdataCapture;

   // Guard on the registered strobe so a second backend strobe cannot double-return.
   assign rdataCapture = i_mem_rdata_valid && rdPending_q && !rdataValid_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdataValid_q <= 1'b0;
         rdata_q      <= '0;
      end else begin
         rdataValid_q <= rdataCapture;
         if (rdataCapture)
            rdata_q <= i_mem_rdata;
      end
   end

   assign o_rdata_valid = rdataValid_q;
   assign o_rdata       = rdata_q;
   assign rdataDone     = rdataValid_q;
`else
   assign o_rdata_valid = i_mem_rdata_valid && rdPending_q;
   assign o_rdata       = i_mem_rdata;
   assign rdataDone     = o_rdata_valid;
`endif

endmodule

// File: tb/tb_a25_wishbone_resp_buf.sv
// Directed self-checking bench for a25_wishbone_resp_buf: per-cycle vector table plus
// hand-written sequences for read return, pending-read blocking, spurious data and async reset.
module tb_a25_wishbone_resp_buf;

   localparam int DW = 128;
   localparam int AW = 32;
   localparam int BW = DW / 8;

   logic          clk;
   logic          rstN;
   logic          valid, write, memReady, memRdataValid;
   logic [DW-1:0] wdata, memRdata;
   logic [BW-1:0] be;
   logic [AW-1:0] addr;
   logic          accepted, rdataValid, memReq, memWrite;
   logic [DW-1:0] rdata, memWdata;
   logic [BW-1:0] memBe;
   logic [AW-1:0] memAddr;

   int checks = 0;
   int errors = 0;

   a25_wishbone_resp_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .i_clk             (clk),
      .i_rst_n           (rstN),
      .i_valid           (valid),
      .o_accepted        (accepted),
      .i_write           (write),
      .i_wdata           (wdata),
      .i_be              (be),
      .i_addr            (addr),
      .o_rdata           (rdata),
      .o_rdata_valid     (rdataValid),
      .o_mem_req         (memReq),
      .i_mem_ready       (memReady),
      .o_mem_write       (memWrite),
      .o_mem_wdata       (memWdata),
      .o_mem_be          (memBe),
      .o_mem_addr        (memAddr),
      .i_mem_rdata       (memRdata),
      .i_mem_rdata_valid (memRdataValid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [15:0] be;
      logic        memReady;
      logic        expAcc;
      logic        expMemReq;
      logic        expMemWrite;
      logic [31:0] expMemAddr;
      logic [31:0] expMemWdata;
      logic [15:0] expMemBe;
   } vec_t;

   vec_t vecs[14];

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [15:0] b, input logic rdy,
                                input logic rv, input logic [31:0] rd);
      valid         = v;
      write         = w;
      addr          = a;
      wdata         = DW'(d);
      be            = b;
      memReady      = rdy;
      memRdataValid = rv;
      memRdata      = DW'(rd);
   endtask

   // Inputs change at posedge+1; outputs are sampled mid-cycle at posedge+5.
   task automatic midCycle();
      #4;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkMemHead(input string tag, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [15:0] b);
      checkOutput({tag, "_memReq"}, DW'(memReq), DW'(1'b1));
      checkOutput({tag, "_memWrite"}, DW'(memWrite), DW'(w));
      checkOutput({tag, "_memAddr"}, DW'(memAddr), DW'(a));
      checkOutput({tag, "_memBe"}, DW'(memBe), DW'(b));
      if (w)
         checkOutput({tag, "_memWdata"}, memWdata, DW'(d));
   endtask

   // Returns read data from the backend and checks the response strobe timing for the build.
   task automatic readReturn(input string tag, input logic [31:0] d);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b1, 1'b1, d);
      midCycle();
`ifdef A25_WB_RESP_RDATA_REG_EN
      checkOutput({tag, "_rvEarly"}, DW'(rdataValid), DW'(1'b0));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
`endif
      checkOutput({tag, "_rv"}, DW'(rdataValid), DW'(1'b1));
      checkOutput({tag, "_rdata"}, rdata, DW'(d));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkOutput({tag, "_rvDone"}, DW'(rdataValid), DW'(1'b0));
      nextCycle();
   endtask

   initial begin
      // valid write addr wdata be rdy | acc req mwr maddr mwdata mbe
      vecs[0]  = '{1'b0, 1'b0, 32'h0,   32'h0,        16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        16'h0};
      vecs[1]  = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 16'h000F, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        16'h0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,   32'h0,        16'h0,    1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 16'h000F};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,        16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        16'h0};
      vecs[4]  = '{1'b1, 1'b1, 32'h0,   32'h11,       16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        16'h0};
      vecs[5]  = '{1'b1, 1'b1, 32'h10,  32'h22,       16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,   32'h11,       16'hFFFF};
      vecs[6]  = '{1'b1, 1'b1, 32'h20,  32'h33,       16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h11,       16'hFFFF};
      vecs[7]  = '{1'b1, 1'b1, 32'h20,  32'h33,       16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,   32'h11,       16'hFFFF};
      vecs[8]  = '{1'b1, 1'b1, 32'h20,  32'h33,       16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10,  32'h22,       16'hFFFF};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,        16'h0,    1'b1, 1'b0, 1'b1, 1'b1, 32'h20,  32'h33,       16'hFFFF};
      vecs[10] = '{1'b0, 1'b0, 32'h0,   32'h0,        16'h0,    1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        16'h0};
      vecs[11] = '{1'b1, 1'b1, 32'h40,  32'h44,       16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        16'h0};
      vecs[12] = '{1'b1, 1'b0, 32'h40,  32'h0,        16'h0003, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40,  32'h44,       16'h00FF};
      vecs[13] = '{1'b0, 1'b0, 32'h0,   32'h0,        16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h40,  32'h0,        16'hFFFF};

      rstN = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #4;
      checkOutput("rst_memReq", DW'(memReq), DW'(1'b0));
      checkOutput("rst_rdataValid", DW'(rdataValid), DW'(1'b0));
      checkOutput("rst_accepted", DW'(accepted), DW'(1'b0));
      checkOutput("rst_rdata", rdata, '0);
      nextCycle();
      rstN = 1'b1;

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                       vecs[i].memReady, 1'b0, 32'h0);
         midCycle();
         checkOutput($sformatf("v%0d_accepted", i), DW'(accepted), DW'(vecs[i].expAcc));
         checkOutput($sformatf("v%0d_memReq", i), DW'(memReq), DW'(vecs[i].expMemReq));
         checkOutput($sformatf("v%0d_rdataValid", i), DW'(rdataValid), DW'(1'b0));
         if (vecs[i].expMemReq)
            checkMemHead($sformatf("v%0d", i), vecs[i].expMemWrite, vecs[i].expMemAddr,
                         vecs[i].expMemWdata, vecs[i].expMemBe);
         nextCycle();
      end

      readReturn("ret1234", 32'h1234);

      // A second read is blocked while one is outstanding, but writes still flow.
      applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkOutput("b1_accRead80", DW'(accepted), DW'(1'b1));
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkOutput("b2_blockRead90", DW'(accepted), DW'(1'b0));
      checkMemHead("b2", 1'b0, 32'h80, 32'h0, 16'hFFFF);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'hA0, 32'hAA, 16'h000F, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkOutput("b3_accWriteA0", DW'(accepted), DW'(1'b1));
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkOutput("b4_blockRead90", DW'(accepted), DW'(1'b0));
      checkMemHead("b4", 1'b1, 32'hA0, 32'hAA, 16'h000F);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 16'h0, 1'b1, 1'b1, 32'h5678);
      midCycle();
      checkOutput("b5_blockRead90", DW'(accepted), DW'(1'b0));
`ifdef A25_WB_RESP_RDATA_REG_EN
      checkOutput("b5_rv", DW'(rdataValid), DW'(1'b0));
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkOutput("b6_blockRead90", DW'(accepted), DW'(1'b0));
`endif
      checkOutput("b_rv", DW'(rdataValid), DW'(1'b1));
      checkOutput("b_rdata", rdata, DW'(32'h5678));
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkOutput("b_accRead90", DW'(accepted), DW'(1'b1));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkMemHead("b_read90", 1'b0, 32'h90, 32'h0, 16'hFFFF);
      nextCycle();
      readReturn("retCafe", 32'hCAFE);

      // Backend strobe with nothing pending must be ignored.
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b1, 1'b1, 32'hBAD);
      midCycle();
      checkOutput("spur_rv", DW'(rdataValid), DW'(1'b0));
      checkOutput("spur_memReq", DW'(memReq), DW'(1'b0));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkOutput("spur_rvAfter", DW'(rdataValid), DW'(1'b0));
      checkOutput("spur_memReqAfter", DW'(memReq), DW'(1'b0));
      nextCycle();

      // Async reset with two entries queued and a read outstanding.
      applyStimulus(1'b1, 1'b1, 32'h200, 32'h77, 16'h00FF, 1'b0, 1'b0, 32'h0);
      midCycle();
      checkOutput("r_accW200", DW'(accepted), DW'(1'b1));
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h210, 32'h0, 16'h0, 1'b0, 1'b0, 32'h0);
      midCycle();
      checkOutput("r_accR210", DW'(accepted), DW'(1'b1));
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0, 1'b1, 32'hEEEE);
      #1;
      checkOutput("r_preMemReq", DW'(memReq), DW'(1'b1));
      #1;
      rstN = 1'b0;
      #1;
      checkOutput("r_memReqInReset", DW'(memReq), DW'(1'b0));
      checkOutput("r_rvInReset", DW'(rdataValid), DW'(1'b0));
      nextCycle();
      rstN = 1'b1;
      midCycle();
      checkOutput("r_rvAfterRelease", DW'(rdataValid), DW'(1'b0));
      checkOutput("r_memReqAfterRelease", DW'(memReq), DW'(1'b0));
      nextCycle();
      applyStimulus(1'b1, 1'b1, 32'h300, 32'h99, 16'h00F0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkOutput("r_accW300", DW'(accepted), DW'(1'b1));
      nextCycle();
      applyStimulus(1'b1, 1'b0, 32'h310, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkOutput("r_accR310", DW'(accepted), DW'(1'b1));
      checkMemHead("r_w300", 1'b1, 32'h300, 32'h99, 16'h00F0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b1, 1'b0, 32'h0);
      midCycle();
      checkMemHead("r_r310", 1'b0, 32'h310, 32'h0, 16'hFFFF);
      nextCycle();
      readReturn("retAbcd", 32'hABCD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
